// File: rtl/gf_poly_eval.sv
// gf_poly_eval: multi-channel GF(2^M) Horner polynomial evaluator
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_start, i_alpha, i_len   start an evaluation of i_len coefs at NCH points
//   i_coef, i_coef_valid      coefficient stream, highest degree first
//   o_coef_ready              coefficient accepted this cycle (LOAD)
//   o_busy                    high in LOAD and DONE
//   o_res, o_res_valid        per-channel results, held until i_res_ready
//   i_res_ready               consumer accepts o_res
module gf_poly_eval #(
    parameter int M = 5,
    parameter logic [M-1:0] POLY = 5'b00101,
    parameter int NCH = 4,
    parameter int LEN_W = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NCH*M-1:0]   i_alpha,
    input  logic [LEN_W-1:0]   i_len,
    input  logic [M-1:0]       i_coef,
    input  logic               i_coef_valid,
    output logic               o_coef_ready,
    output logic               o_busy,
    output logic [NCH*M-1:0]   o_res,
    output logic               o_res_valid,
    input  logic               i_res_ready
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [NCH*M-1:0]   r_alpha, r_acc, w_acc_nx;
    logic [LEN_W-1:0]   r_cnt;
    logic               w_take, w_xfer;

    // MSB-first shift-and-add; each left shift is folded back by POLY
    function automatic logic [M-1:0] gfmul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        p = '0;
        for (int k = M - 1; k >= 0; k--)
            p = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY : '0) ^ (b[k] ? a : '0);
        return p;
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign w_acc_nx[c*M +: M] = gfmul(r_acc[c*M +: M], r_alpha[c*M +: M]) ^ i_coef;
    end

    assign w_take = (r_state == S_IDLE) && i_start;
    assign w_xfer = (r_state == S_LOAD) && i_coef_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? ((i_len == '0) ? S_DONE : S_LOAD) : S_IDLE;
            S_LOAD:  w_next = (w_xfer && r_cnt == LEN_W'(1)) ? S_DONE : S_LOAD;
            S_DONE:  w_next = i_res_ready ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_alpha <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_alpha <= i_alpha;
                r_cnt   <= i_len;
                r_acc   <= '0;
            end else if (w_xfer) begin
                r_acc   <= w_acc_nx;
                r_cnt   <= r_cnt - 1'b1;
            end
        end
    end

    assign o_coef_ready = (r_state == S_LOAD);
    assign o_busy       = (r_state != S_IDLE);
    assign o_res_valid  = (r_state == S_DONE);
    assign o_res        = r_acc;
endmodule

// File: tb/tb_gf_poly_eval.sv
// tb_gf_poly_eval: directed self-checking bench for gf_poly_eval
module tb_gf_poly_eval;
    logic        clk = 0;
    logic        rst;
    logic        start;
    logic [19:0] alpha;
    logic [5:0]  len;
    logic [4:0]  coef;
    logic        coef_valid;
    logic        coef_ready;
    logic        busy;
    logic [19:0] res;
    logic        res_valid;
    logic        res_ready;

    int checks = 0;
    int errors = 0;
    logic [4:0] coefs [0:63];

    localparam logic [19:0] ALPHAS = {5'd3, 5'd0, 5'd1, 5'd2};
    localparam logic [19:0] EXP1   = {5'd22, 5'd0, 5'd1, 5'd5};
    localparam logic [19:0] EXP2   = {5'd2, 5'd1, 5'd0, 5'd3};
    localparam logic [19:0] EXP3   = {5'd1, 5'd0, 5'd1, 5'd1};

    gf_poly_eval dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_alpha(alpha), .i_len(len),
        .i_coef(coef), .i_coef_valid(coef_valid), .o_coef_ready(coef_ready),
        .o_busy(busy), .o_res(res), .o_res_valid(res_valid), .i_res_ready(res_ready)
    );

    always #5 clk = ~clk;

    task automatic load_poly1();
        for (int i = 0; i < 64; i++) coefs[i] = 5'd0;
        coefs[0] = 5'd1;
    endtask

    task automatic load_poly2();
        for (int i = 0; i < 64; i++) coefs[i] = 5'd0;
        coefs[0] = 5'd1;
        coefs[1] = 5'd1;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; alpha = '0; len = '0; coef = '0; coef_valid = 0; res_ready = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({coef_ready, busy, res_valid, res} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b busy=%b valid=%b res=%h, want all 0",
                     coef_ready, busy, res_valid, res);
        end
        rst = 0;
        @(negedge clk);
    endtask

    // one evaluation from IDLE: start, stream len coefs (optionally gapped), check, handshake
    task automatic test_horner(input string name, input logic [5:0] l, input bit gap,
                               input logic [19:0] exp_res);
        int n = 0;
        int k = 0;
        bit xfer;
        alpha = ALPHAS; len = l; start = 1;
        @(negedge clk);
        start = 0; alpha = '1; len = 6'd9;
        checks++;
        if (coef_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_load_entry: ready=%b valid=%b busy=%b, want 1 0 1",
                     name, coef_ready, res_valid, busy);
        end
        while (n < l && k < 400) begin
            coef = coefs[n];
            coef_valid = gap ? (k % 3 == 0) : 1'b1;
            xfer = coef_valid && coef_ready;
            @(negedge clk);
            k++;
            if (xfer) n++;
        end
        coef_valid = 0;
        checks++;
        if (n != l || (!gap && k != l)) begin
            errors++;
            $display("FAIL %s_accept: accepted %0d in %0d cycles, want %0d", name, n, k, l);
        end
        checks++;
        if (res_valid !== 1'b1 || coef_ready !== 1'b0 || res !== exp_res) begin
            errors++;
            $display("FAIL %s_result: valid=%b ready=%b res=%h, want valid=1 ready=0 res=%h",
                     name, res_valid, coef_ready, res, exp_res);
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_handshake: valid=%b busy=%b, want 0 0", name, res_valid, busy);
        end
    endtask

    task automatic test_start_ignored_and_hold();
        logic [19:0] held;
        alpha = ALPHAS; len = 6'd2; start = 1;
        @(negedge clk);
        alpha = {5'd7, 5'd7, 5'd7, 5'd7}; len = 6'd5;
        coef = 5'd1; coef_valid = 1;
        @(negedge clk);
        coef = 5'd1;
        @(negedge clk);
        coef_valid = 0;
        held = res;
        checks++;
        if (res_valid !== 1'b1 || res !== EXP2) begin
            errors++;
            $display("FAIL start_in_load: valid=%b res=%h, want 1 %h", res_valid, res, EXP2);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res !== held) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b res=%h, want 1 %h", i, res_valid, res, held);
            end
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0; start = 0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || coef_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_at_handshake: busy=%b valid=%b ready=%b, want IDLE 0 0 0",
                     busy, res_valid, coef_ready);
        end
    endtask

    task automatic test_len_zero();
        alpha = ALPHAS; len = 6'd0; start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (res_valid !== 1'b1 || res !== 20'd0 || coef_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL len_zero_result: valid=%b res=%h ready=%b busy=%b, want 1 0 0 1",
                     res_valid, res, coef_ready, busy);
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL len_zero_handshake: busy=%b valid=%b, want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        load_poly1();
        alpha = ALPHAS; len = 6'd6; start = 1;
        @(negedge clk);
        start = 0; coef_valid = 1;
        for (int i = 0; i < 3; i++) begin
            coef = coefs[i];
            @(negedge clk);
        end
        coef_valid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        checks++;
        if ({coef_ready, busy, res_valid, res} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid_load: ready=%b busy=%b valid=%b res=%h, want all 0",
                     coef_ready, busy, res_valid, res);
        end
        test_horner("after_reset", 6'd6, 1'b0, EXP1);
    endtask

    initial begin
        test_reset();
        load_poly1();
        test_horner("poly_x5", 6'd6, 1'b0, EXP1);
        load_poly2();
        test_horner("poly_x1", 6'd2, 1'b0, EXP2);
        load_poly1();
        test_horner("pow31", 6'd32, 1'b0, EXP3);
        load_poly2();
        test_horner("gapped", 6'd2, 1'b1, EXP2);
        test_start_ignored_and_hold();
        test_len_zero();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gf_poly_eval.md
# gf_poly_eval

Parametrised multi-channel GF(2^M) polynomial evaluator built on Horner's rule. It accepts a stream of polynomial coefficients, highest degree first, and evaluates that polynomial at NCH field points in parallel. It is the shared engine for syndrome computation and Chien-style root search in the RS decoder. It generalises the fixed 5-bit GF adder/multiplier primitives to arbitrary M and reduction polynomial, and adds sequencing, handshakes and result buffering.

## Interface
- M, default 5: symbol width in bits; polynomial basis, bit 0 = coefficient of x^0.
- POLY, default 5'b00101: low M bits of the primitive polynomial; the x^M term is implicit. Default is x^5+x^2+1.
- NCH, default 4: number of evaluation points (channels) computed in parallel.
- LEN_W, default 6: width of the coefficient-count input.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin evaluation; sampled only in IDLE.
- alpha  in  NCH*M  evaluation points, channel i at [i*M +: M]; latched on start.
- len  in  LEN_W  number of coefficients (0..2^LEN_W-1); latched on start.
- coef  in  M  coefficient, highest degree first.
- coef_valid  in  1  coef is valid.
- coef_ready  out  1  block accepts coef this cycle.
- busy  out  1  high in LOAD and DONE.
- res  out  NCH*M  results, channel i at [i*M +: M].
- res_valid  out  1  res is valid.
- res_ready  in  1  consumer accepts res.

## Operation
- States: IDLE, LOAD, DONE.
- **IDLE**
  - start=1, len≠0: latch alpha and len into alpha_r and cnt; clear all acc_i to 0; go to LOAD.
  - start=1, len=0: clear acc; go directly to DONE. Results are all zero.
- **LOAD**
  - coef_ready=1. Each transfer (coef_valid & coef_ready) performs acc_i <= gfmul(acc_i, alpha_r_i) XOR coef for every channel, and decrements cnt.
  - When the transfer with cnt==1 occurs, go to DONE.
  - No transfer leaves acc and cnt unchanged.
- **DONE**
  - res_valid=1 and res=acc, held stable until res_ready=1.
  - On res_valid & res_ready, go to IDLE.
- gfmul is combinational GF(2^M) multiplication: a shift-and-add over M partial products, each reduced by POLY. Results are always M-bit and field-exact; no carries.
- start outside IDLE is ignored, and alpha/len changes outside IDLE have no effect.
- coef_valid outside LOAD is ignored (coef_ready=0 there).
- start in the same cycle as the DONE handshake is ignored; start is taken only once the block is in IDLE.
- **Reset**, in any state including mid-LOAD, gives on the next edge:
  - state=IDLE
  - acc=0, cnt=0, alpha_r=0
  - coef_ready=0, busy=0, res_valid=0, res=0
  - Any partial evaluation is discarded.

## Timing
- All outputs are decoded from registered state and acc; there is no combinational path from inputs to outputs.
- Sustained throughput is one coefficient per cycle per channel.
- With start at cycle 0 and coef_valid held high:
  - LOAD from cycle 1.
  - Coefficients accepted on cycles 1..len.
  - res_valid=1 from cycle len+1.
- With len=0: start at cycle 0 gives res_valid=1 at cycle 1.
- Back-to-back evaluations: the earliest next start is the cycle after the DONE handshake. That gives a minimum of len+2 cycles per evaluation.
- gfmul plus XOR sits on the single-cycle acc path. Timing closure at M≤8 is required without pipelining.

## Test plan
- Defaults; alpha ch0..3 = {2,1,0,3}; len=6; coefs 1,0,0,0,0,0 with valid held high -> res_valid at cycle 7; res ch0=5, ch1=1, ch2=0, ch3=22.
- len=2; coefs 1,1 (x+1); same alphas -> ch0=3, ch1=0, ch2=1, ch3=2.
- len=32; coef 1 then 31 zeros; same alphas (checks a^31=1) -> ch0=1, ch1=1, ch2=0, ch3=1.
- Backpressure:
  - coef_valid toggled 1,0,0,1,... during the test-2 sequence -> identical results.
  - Hold res_ready=0 for 5 cycles -> res and res_valid stable throughout.
  - start pulsed during LOAD and DONE -> ignored.
- len=0 with start -> res_valid at cycle 1 with res=0; a handshake then returns to IDLE.
- reset asserted after 3 of 6 coefficients -> next cycle all outputs 0 and state IDLE; a fresh start of test 1 -> correct results.
